// File: rtl/counter_pkg.sv
// Shared constants for the tick-divided counter family.
// Direction/mode encodings, default divider values and a width helper.
package counter_pkg;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam int DIV_COUNT_SIM = 646;
   localparam int DIV_COUNT_1HZ = 100_000_000;

   // Prescaler register width; never below one bit.
   function automatic int presc_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every DIV_COUNT enabled cycles.
// Ports: clk, rst (async high), en (advance), sclr (sync restart at phase 0), tick.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int DIV_COUNT = DIV_COUNT_SIM
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sclr,
   output logic tick
);

   localparam int PRESC_W = presc_width(DIV_COUNT);
   localparam logic [PRESC_W-1:0] LAST = PRESC_W'(DIV_COUNT - 1);
   localparam logic [PRESC_W-1:0] STEP = PRESC_W'(1);

   logic [PRESC_W-1:0] presc_cnt;
   logic [PRESC_W-1:0] presc_nxt;
   logic               at_last;

   assign at_last = (presc_cnt == LAST);

   always_comb begin
      presc_nxt = at_last ? '0 : presc_cnt + STEP;
   end

   // Holding while en=0 keeps the phase, so a resumed run
   // finishes the interrupted period instead of starting over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt <= '0;
      end else if (sclr) begin
         presc_cnt <= '0;
      end else if (en) begin
         presc_cnt <= presc_nxt;
      end
   end

   assign tick = en & at_last;

endmodule

// File: rtl/counter_tick_div.sv
// Up/down counter advanced by a prescaled tick, with load, clear and terminal pulse.
// Ports: clk, rst, en, clr, load, load_val, up_dn -> count_out, tick_out, tc_out.
module counter_tick_div
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int DIV_COUNT = DIV_COUNT_SIM,
   parameter int SATURATE  = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count_out,
   output logic             tick_out,
   output logic             tc_out
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic             SAT = (SATURATE == MODE_SAT);

   logic             tick;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;

   // A load or clear restarts the tick phase so the next
   // step lands a full period after the new value.
   tick_prescaler #(
      .DIV_COUNT (DIV_COUNT)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sclr (clr | load),
      .tick (tick)
   );

   assign tick_out = tick;

   always_comb begin
      count_nxt = count_out;
      tc_nxt    = 1'b0;
      if (clr) begin
         count_nxt = '0;
      end else if (load) begin
         count_nxt = (load_val > MAX) ? MAX : load_val;
      end else if (tick) begin
         if (up_dn == DIR_UP) begin
            if (count_out == MAX) begin
               tc_nxt    = 1'b1;
               count_nxt = SAT ? MAX : '0;
            end else begin
               count_nxt = count_out + ONE;
            end
         end else begin
            if (count_out == '0) begin
               tc_nxt    = 1'b1;
               count_nxt = SAT ? '0 : MAX;
            end else begin
               count_nxt = count_out - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_out <= '0;
         tc_out    <= 1'b0;
      end else begin
         count_out <= count_nxt;
         tc_out    <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_counter_tick_div.sv
// Scoreboard bench for counter_tick_div across four parameter sets.
// 0: wrap/15/div4, 1: wrap/10/div4, 2: sat/15/div4, 3: wrap/15/div1.
module tb_counter_tick_div;

   typedef struct packed {
      int         id;
      int         cyc;
      logic [3:0] cnt;
      logic       tc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] en_v;
   logic [3:0] clr_v;
   logic [3:0] load_v;
   logic [3:0] up_v;
   logic [3:0] lv_v [4];
   logic [3:0] cnt_v [4];
   logic [3:0] tick_v;
   logic [3:0] tc_v;

   int   cyc   = 0;
   int   nrun  = 0;
   int   nfail = 0;
   exp_t sbq[$];
   logic [3:0] last [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

   counter_tick_div #(
      .WIDTH(4), .MAX_VAL(15), .DIV_COUNT(4), .SATURATE(0)
   ) u_a (
      .clk(clk), .rst(rst), .en(en_v[0]), .clr(clr_v[0]),
      .load(load_v[0]), .load_val(lv_v[0]), .up_dn(up_v[0]),
      .count_out(cnt_v[0]), .tick_out(tick_v[0]), .tc_out(tc_v[0])
   );

   counter_tick_div #(
      .WIDTH(4), .MAX_VAL(10), .DIV_COUNT(4), .SATURATE(0)
   ) u_b (
      .clk(clk), .rst(rst), .en(en_v[1]), .clr(clr_v[1]),
      .load(load_v[1]), .load_val(lv_v[1]), .up_dn(up_v[1]),
      .count_out(cnt_v[1]), .tick_out(tick_v[1]), .tc_out(tc_v[1])
   );

   counter_tick_div #(
      .WIDTH(4), .MAX_VAL(15), .DIV_COUNT(4), .SATURATE(1)
   ) u_c (
      .clk(clk), .rst(rst), .en(en_v[2]), .clr(clr_v[2]),
      .load(load_v[2]), .load_val(lv_v[2]), .up_dn(up_v[2]),
      .count_out(cnt_v[2]), .tick_out(tick_v[2]), .tc_out(tc_v[2])
   );

   counter_tick_div #(
      .WIDTH(4), .MAX_VAL(15), .DIV_COUNT(1), .SATURATE(0)
   ) u_d (
      .clk(clk), .rst(rst), .en(en_v[3]), .clr(clr_v[3]),
      .load(load_v[3]), .load_val(lv_v[3]), .up_dn(up_v[3]),
      .count_out(cnt_v[3]), .tick_out(tick_v[3]), .tc_out(tc_v[3])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #50000;
      $display("FAIL watchdog: cyc=%0d, required finish", cyc);
      $fatal(1, "timeout");
   end

   task automatic push(input int id, input int c, input int cnt, input bit tc);
      exp_t e;
      e.id  = id;
      e.cyc = c;
      e.cnt = 4'(cnt);
      e.tc  = tc;
      sbq.push_back(e);
   endtask

   task automatic chk(input string nm, input int got, input int want);
      nrun++;
      if (got != want) begin
         nfail++;
         $display("FAIL %s: got %0d, required %0d", nm, got, want);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_upd(input int i);
      exp_t e;
      nrun++;
      if (sbq.size() == 0) begin
         nfail++;
         $display("FAIL upd[%0d] cyc=%0d: got cnt=%0d tc=%b, required no update",
                  i, cyc, cnt_v[i], tc_v[i]);
      end else begin
         e = sbq.pop_front();
         if (e.id != i || e.cyc != cyc || cnt_v[i] !== e.cnt || tc_v[i] !== e.tc) begin
            nfail++;
            $display("FAIL upd[%0d]: got cnt=%0d tc=%b at cyc %0d, required inst %0d cnt=%0d tc=%b at cyc %0d",
                     i, cnt_v[i], tc_v[i], cyc, e.id, e.cnt, e.tc, e.cyc);
         end
      end
   endtask

   // Monitor: any edge where a tick, load or clear was presented
   // must match the next scoreboard entry; every other edge must
   // leave the count unchanged with tc low.
   always @(posedge clk) begin : mon
      logic [3:0] ev;
      logic       rs;
      ev = tick_v | load_v | clr_v;
      #1;
      rs = rst;
      for (int i = 0; i < 4; i++) begin
         if (ev[i]) begin
            check_upd(i);
         end else if (!rs) begin
            nrun++;
            if (cnt_v[i] !== last[i] || tc_v[i] !== 1'b0) begin
               nfail++;
               $display("FAIL idle[%0d] cyc=%0d: got cnt=%0d tc=%b, required cnt=%0d tc=0",
                        i, cyc, cnt_v[i], tc_v[i], last[i]);
            end
         end
         last[i] = cnt_v[i];
      end
   end

   initial begin
      int b;
      rst    = 1'b1;
      en_v   = '0;
      clr_v  = '0;
      load_v = '0;
      up_v   = '0;
      for (int i = 0; i < 4; i++) lv_v[i] = '0;

      wait_to(2);
      for (int i = 0; i < 4; i++) begin
         chk("rst_cnt", int'(cnt_v[i]), 0);
         chk("rst_tc", int'(tc_v[i]), 0);
         chk("rst_tick", int'(tick_v[i]), 0);
      end

      // A: full wrap run, first tick on the 4th cycle
      b = 3;
      wait_to(b);
      rst     = 1'b0;
      en_v[0] = 1'b1;
      up_v[0] = 1'b1;
      for (int k = 1; k <= 16; k++) push(0, b + 4 * k, k % 16, k == 16);

      // A: freeze at phase 2, resume ticks 2 cycles later
      wait_to(b + 66);
      en_v[0] = 1'b0;
      wait_to(b + 76);
      for (int j = 0; j < 7; j++) push(0, b + 78 + 4 * j, 1 + j, 1'b0);
      en_v[0] = 1'b1;

      // A: async reset between edges at count 7
      wait_to(b + 103);
      #2 rst = 1'b1;
      #1;
      chk("arst_cnt", int'(cnt_v[0]), 0);
      chk("arst_tc", int'(tc_v[0]), 0);
      chk("arst_tick", int'(tick_v[0]), 0);
      wait_to(b + 105);
      rst = 1'b0;
      b   = b + 105;
      push(0, b + 4, 1, 1'b0);

      // A: clr beats load, prescaler restarts; then down-wrap
      wait_to(b + 5);
      clr_v[0]  = 1'b1;
      load_v[0] = 1'b1;
      lv_v[0]   = 4'd5;
      push(0, b + 6, 0, 1'b0);
      push(0, b + 10, 1, 1'b0);
      push(0, b + 14, 0, 1'b0);
      push(0, b + 18, 15, 1'b1);
      wait_to(b + 6);
      clr_v[0]  = 1'b0;
      load_v[0] = 1'b0;
      wait_to(b + 10);
      up_v[0] = 1'b0;
      wait_to(b + 18);
      en_v[0] = 1'b0;

      // C: saturating down count from 2
      wait_to(b + 20);
      b = b + 20;
      load_v[2] = 1'b1;
      lv_v[2]   = 4'd2;
      en_v[2]   = 1'b1;
      up_v[2]   = 1'b0;
      push(2, b + 1, 2, 1'b0);
      push(2, b + 5, 1, 1'b0);
      push(2, b + 9, 0, 1'b0);
      push(2, b + 13, 0, 1'b1);
      push(2, b + 17, 0, 1'b1);
      wait_to(b + 1);
      load_v[2] = 1'b0;
      wait_to(b + 17);
      en_v[2] = 1'b0;

      // B: clamped load over a tick, then wrap from MAX_VAL=10
      wait_to(b + 19);
      b = b + 19;
      en_v[1] = 1'b1;
      up_v[1] = 1'b1;
      push(1, b + 4, 1, 1'b0);
      push(1, b + 8, 2, 1'b0);
      push(1, b + 12, 10, 1'b0);
      push(1, b + 16, 0, 1'b1);
      wait_to(b + 11);
      load_v[1] = 1'b1;
      lv_v[1]   = 4'd12;
      wait_to(b + 12);
      load_v[1] = 1'b0;
      wait_to(b + 16);
      en_v[1] = 1'b0;

      // D: DIV_COUNT=1 counts every cycle
      wait_to(b + 18);
      b = b + 18;
      en_v[3] = 1'b1;
      up_v[3] = 1'b1;
      #1 chk("d_tick_on", int'(tick_v[3]), 1);
      for (int k = 1; k <= 18; k++) push(3, b + k, k % 16, k == 16);
      wait_to(b + 18);
      en_v[3] = 1'b0;
      #1 chk("d_tick_off", int'(tick_v[3]), 0);

      wait_to(b + 22);
      chk("sb_left", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end

endmodule

// File: doc/counter_tick_div.md
Name: counter_tick_div

Overview:
- Parametrised successor to the 4-bit divided-clock counter.
- A prescaler produces a one-cycle tick enable every DIV_COUNT cycles. A WIDTH-bit up/down counter advances on that tick.
- Everything runs in the single clk domain. There is no derived clock.
- Adds load, synchronous clear, direction control, wrap/saturate mode and a terminal-count pulse. Drives LED/display demo logic and slow timers.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX_VAL, 2**WIDTH-1, terminal value for up-count; must be ≤ 2**WIDTH-1 and ≥ 1.
- DIV_COUNT, 646, clk cycles per tick; ≥ 1. Use 646 for simulation, 100_000_000 for a 1 Hz bitstream.
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.
- PRESC_W (localparam), max(1, $clog2(DIV_COUNT)), prescaler width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advances the prescaler; 0 freezes prescaler and counter.
- clr  in  1  synchronous clear of counter and prescaler.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value for load.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- count_out  out  WIDTH  registered count value.
- tick_out  out  1  one-cycle tick enable; exported for chaining.
- tc_out  out  1  registered terminal-count pulse.

Behaviour:
- Reset: when rst=1, asynchronously set presc_cnt=0, count_out=0, tc_out=0; tick_out=0 follows. Reset asserted mid-count aborts immediately. On release, counting restarts from phase 0.
- Prescaler:
  - When en=1, presc_cnt counts 0..DIV_COUNT-1 and wraps to 0.
  - tick_out = en & (presc_cnt==DIV_COUNT-1). It is combinational from the register and en only.
  - With DIV_COUNT=1, tick_out=en every cycle.
  - When en=0, presc_cnt holds and phase is preserved on resume.
- Priority per clock edge: clr > load > tick > hold.
- clr=1: count_out←0, presc_cnt←0, tc_out←0. Any coincident load or tick is ignored.
- load=1 (clr=0):
  - count_out ← min(load_val, MAX_VAL); presc_cnt←0; tc_out←0.
  - A coincident tick is discarded.
  - load works regardless of en.
- tick with up_dn=1:
  - count_out<MAX_VAL → count_out+1.
  - count_out==MAX_VAL → 0 if SATURATE=0, otherwise hold MAX_VAL.
- tick with up_dn=0:
  - count_out>0 → count_out-1.
  - count_out==0 → MAX_VAL if SATURATE=0, otherwise hold 0.
- Terminal-count pulse:
  - tc_out←1 for exactly one cycle after any tick taken while count_out was at terminal value: MAX_VAL when counting up, 0 when counting down.
  - In saturate mode it pulses on every tick while held at terminal.
  - Otherwise tc_out←0.
- Out-of-range count: if count_out > MAX_VAL is reachable only via a MAX_VAL change (no runtime path), no special handling is required.
- Arithmetic: modulo-free, width WIDTH. No intermediate wider than WIDTH+1.
- Latency:
  - count_out updates on the edge closing the tick cycle.
  - tc_out is aligned with the new count_out.
  - First tick after reset with en held at 1 falls in cycle DIV_COUNT (1-based).

Decomposition:
- Package counter_pkg: constants DIR_DOWN=0 / DIR_UP=1, MODE_WRAP=0 / MODE_SAT=1, default DIV_COUNT_SIM=646 and DIV_COUNT_1HZ=100_000_000.
- Sub-module tick_prescaler:
  - Parameter DIV_COUNT.
  - Ports clk, rst, en, sclr, tick.
  - sclr is driven by clr|load.
  - Reusable by other slow-rate blocks.
- Counter/tc logic lives in the top module.

Test Plan (WIDTH=4, DIV_COUNT=4 unless noted):
- Assert rst mid-count at count_out=7, asynchronously between edges → count_out=0, tc_out=0, tick_out=0 before the next edge. After release with en=1 → first tick in the 4th cycle.
- en=1, up_dn=1, MAX_VAL=15, SATURATE=0, run 70 cycles → count_out steps every 4 cycles: 0,1,…,15,0. tc_out=1 for one cycle together with the 15→0 transition only.
- SATURATE=1, up_dn=0, load 2 → sequence 2,1,0,0,0. tc_out pulses after the 3rd and each later tick.
- MAX_VAL=10, load=1 with load_val=12 coincident with tick_out=1 → count_out=10, presc_cnt restarts, next tick 4 cycles later. Up-tick then → count_out=0, tc_out=1.
- en dropped at presc_cnt=2 for 10 cycles → count_out and presc_cnt frozen. After en=1, the tick occurs 2 cycles later, not 4.
- clr=1 and load=1 (load_val=5) same cycle → count_out=0, presc_cnt=0. DIV_COUNT=1 variant: en=1 → count_out increments every cycle.
